// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single shared memory port.
// One transaction in flight at a time, fair alternation on contention, with a BUSY timeout.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_i,
  input  logic [31:0]      if_addr_i,
  input  logic             if_flush_i,
  output logic             if_ack_o,
  output logic [31:0]      if_rdata_o,
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic [31:0]      d_addr_i,
  input  logic [31:0]      d_wdata_i,
  output logic             d_ack_o,
  output logic [31:0]      d_rdata_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_ready_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             err_o,
  output logic [CNT_W-1:0] if_wait_cnt_o,
  output logic [CNT_W-1:0] d_wait_cnt_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t           r_state, w_nextState;
  logic             w_grant, w_winData, w_timeout, w_resp;
  logic             r_lastData, r_ownerData, r_flushed, r_timedOut;
  logic             r_memReq, r_memWe;
  logic [31:0]      r_memAddr, r_memWdata, r_respData;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_ifWait, r_dWait;

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // On contention the port that did not win last time gets the memory.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_timeout   = 1'b0;
    w_winData   = d_req_i && (!if_req_i || !r_lastData);
    case (r_state)
      IDLE: begin
        if (if_req_i || d_req_i) begin
          w_grant     = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        w_timeout = !mem_ready_i && (r_timer == TW'(TIMEOUT));
        if (mem_ready_i || w_timeout) w_nextState = RESP;
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_lastData  <= 1'b0;
      r_ownerData <= 1'b0;
      r_flushed   <= 1'b0;
      r_timedOut  <= 1'b0;
      r_memReq    <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_respData  <= '0;
      r_timer     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_lastData  <= w_winData;
            r_ownerData <= w_winData;
            r_flushed   <= !w_winData && if_flush_i;
            r_timedOut  <= 1'b0;
            r_respData  <= '0;
            r_memReq    <= 1'b1;
            r_memWe     <= w_winData && d_we_i;
            r_memAddr   <= w_winData ? d_addr_i : if_addr_i;
            r_memWdata  <= w_winData ? d_wdata_i : 32'd0;
            r_timer     <= TW'(1);
          end
        end
        BUSY: begin
          if (if_flush_i && !r_ownerData) r_flushed <= 1'b1;
          // Memory port is released as soon as the transaction ends, either way.
          if (mem_ready_i || w_timeout) begin
            r_respData <= (mem_ready_i && !r_memWe) ? mem_rdata_i : 32'd0;
            r_timedOut <= w_timeout;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_timer    <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ifWait <= '0;
      r_dWait  <= '0;
    end else begin
      if (if_req_i && !if_ack_o && (r_ifWait != {CNT_W{1'b1}})) r_ifWait <= r_ifWait + CNT_W'(1);
      if (d_req_i && !d_ack_o && (r_dWait != {CNT_W{1'b1}}))    r_dWait  <= r_dWait + CNT_W'(1);
    end
  end

  assign w_resp        = (r_state == RESP);
  assign if_ack_o      = w_resp && !r_ownerData && !r_flushed;
  assign d_ack_o       = w_resp && r_ownerData;
  assign if_rdata_o    = if_ack_o ? r_respData : 32'd0;
  assign d_rdata_o     = d_ack_o ? r_respData : 32'd0;
  assign err_o         = w_resp && r_timedOut;
  assign mem_req_o     = r_memReq;
  assign mem_we_o      = r_memWe;
  assign mem_addr_o    = r_memAddr;
  assign mem_wdata_o   = r_memWdata;
  assign if_wait_cnt_o = r_ifWait;
  assign d_wait_cnt_o  = r_dWait;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum BUSY cycles before forced completion.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each wait counter.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-low.
REQ-005 if_req_i  in  1  fetch read request; held until if_ack_o.
REQ-006 if_addr_i  in  32  fetch byte address; stable while if_req_i is high.
REQ-007 if_flush_i  in  1  pipeline flush; discards the in-flight fetch response.
REQ-008 if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-009 if_rdata_o  out  32  fetch data; valid with if_ack_o.
REQ-010 d_req_i, d_we_i  in  1 each  data request and write-enable; held until d_ack_o.
REQ-011 d_addr_i, d_wdata_i  in  32 each  data address and write data; stable while d_req_i is high.
REQ-012 d_ack_o  out  1  one-cycle data completion pulse.
REQ-013 d_rdata_o  out  32  read data, valid with d_ack_o; 0 for writes.
REQ-014 mem_req_o, mem_we_o  out  1 each  shared-memory request and write strobe.
REQ-015 mem_addr_o, mem_wdata_o  out  32 each  shared-memory address and write data.
REQ-016 mem_ready_i  in  1  memory completion; mem_rdata_i is valid in the same cycle.
REQ-017 mem_rdata_i  in  32  memory read data.
REQ-018 err_o  out  1  one-cycle timeout pulse.
REQ-019 if_wait_cnt_o, d_wait_cnt_o  out  CNT_W each  stall-cycle counters.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, BUSY and RESP, holding at most one outstanding memory transaction.
REQ-021 IDLE with any request sampled high: the block SHALL latch the winner's addr/we/wdata into the mem_* outputs, set mem_req_o=1 and enter BUSY next cycle; with no request it SHALL remain in IDLE.
REQ-022 Arbitration SHALL be as follows:
- only one requester high: that requester wins;
- both high: the requester not granted last wins;
- last_grant updates on every grant.
REQ-023 Fetch grants SHALL drive mem_we_o=0 and mem_wdata_o=0.
REQ-024 BUSY: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be held constant.
REQ-025 BUSY with mem_ready_i=1: the block SHALL capture mem_rdata_i (reads) and enter RESP next cycle.
REQ-026 A BUSY cycle counter SHALL start at 1 on BUSY entry; if it reaches TIMEOUT without mem_ready_i, the block SHALL enter RESP with captured data 0.
REQ-027 RESP lasts exactly one cycle, with the following outputs:
- mem_req_o=0;
- owner's ack=1 with rdata driven;
- err_o=1 only after a timeout;
- next state IDLE.
REQ-028 No grant SHALL occur in RESP, so the still-high req of the just-acked requester is never re-granted.
REQ-029 Minimum latency SHALL be 3 cycles: req sampled at edge 0, BUSY at 1, ready at 1 gives ack at 2.
REQ-030 If if_flush_i is sampled high in any cycle of a fetch-owned transaction (grant through BUSY), if_ack_o for that transaction SHALL be suppressed; the memory cycle still completes and RESP/IDLE sequencing is unchanged.
REQ-031 A requester dropping req mid-transaction SHALL NOT abort it; the ack still pulses.
REQ-032 if_wait_cnt_o SHALL increment each cycle with if_req_i=1 and if_ack_o=0; d_wait_cnt_o likewise for the data port.
REQ-033 Both wait counters SHALL saturate at all-ones and never wrap.
REQ-034 Outputs not otherwise specified SHALL be 0 outside their valid cycle.

Reset
REQ-035 While rst_i=0 at a rising edge, the block SHALL enter IDLE and drive all outputs to 0.
REQ-036 Reset SHALL also clear counters and the BUSY timer and set last_grant=fetch, so data wins the first contention.
REQ-037 Reset mid-BUSY SHALL abandon the transaction: mem_req_o=0 from the next edge, and no ack or err is issued.

Verification
REQ-038 d_req_i=1, d_we_i=0, d_addr=0x0, mem ready after 2 BUSY cycles with rdata=5: ack on the cycle after ready, d_rdata_o=5, d_wait_cnt_o=4 (wait cycles before ack).
REQ-039 Both requests raised together from reset: data granted first, fetch next, then data again; no back-to-back grant to the same requester.
REQ-040 mem_ready_i never asserted: after 16 BUSY cycles RESP occurs with err_o=1, ack=1 and rdata=0.
REQ-041 Fetch in BUSY, if_flush_i pulsed: no if_ack_o, FSM returns to IDLE, and a pending d_req_i is granted next.
REQ-042 rst_i=0 during BUSY: next cycle mem_req_o=0 and counters=0, and no ack ever appears for the abandoned request.
REQ-043 CNT_W=4 with a data request stalled 20 cycles: d_wait_cnt_o holds at 15.
